// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage with single-outstanding imem handshake, IF/ID register and one-entry skid buffer.
// Optional macro PC_ALIGN_CHECK_EN adds the sticky AdELF misaligned-redirect flag.
module fetch_stage #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcD,
  input  logic [WIDTH-1:0] PCBranchD,
  output logic             IMemReq,
  output logic [WIDTH-1:0] IMemAddr,
  input  logic             IMemReady,
  input  logic [WIDTH-1:0] IMemRData,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic             ValidD,
  output logic [WIDTH-1:0] PCF
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             AdELF
`endif
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] pcf_q, pcf_d, redir_pc_q, redir_pc_d;
  logic [WIDTH-1:0] instr_q, instr_d, pcp4_q, pcp4_d;
  logic [WIDTH-1:0] buf_instr_q, buf_instr_d, buf_pcp4_q, buf_pcp4_d;
  logic [WIDTH-1:0] target, fetch_pcp4;
  logic redir_pend_q, redir_pend_d, valid_q, valid_d, buf_valid_q, buf_valid_d;
  logic redir, accept;
  assign redir      = PCSrcD & ~StallD;
  assign target     = PCBranchD & ~WIDTH'(3);
  assign fetch_pcp4 = pcf_q + WIDTH'(4);
  assign accept     = (state_q == REQ) & IMemReady & ~redir_pend_q & ~redir;
  assign IMemReq    = (state_q == REQ);
  assign IMemAddr   = pcf_q;
  assign PCF        = pcf_q;
  assign InstrD     = instr_q;
  assign PCPlus4D   = pcp4_q;
  assign ValidD     = valid_q;
  // IF/ID register and skid buffer
  always_comb begin
    instr_d     = instr_q;
    pcp4_d      = pcp4_q;
    valid_d     = valid_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pcp4_d  = buf_pcp4_q;
    if (StallD) begin
      buf_valid_d = buf_valid_q | accept;
      buf_instr_d = accept ? IMemRData : buf_instr_q;
      buf_pcp4_d  = accept ? fetch_pcp4 : buf_pcp4_q;
    end else if (FlushD | redir) begin
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
    end else if (buf_valid_q) begin
      instr_d     = buf_instr_q;
      pcp4_d      = buf_pcp4_q;
      valid_d     = 1'b1;
      buf_valid_d = accept;
      buf_instr_d = IMemRData;
      buf_pcp4_d  = fetch_pcp4;
    end else begin
      valid_d = accept;
      instr_d = accept ? IMemRData : instr_q;
      pcp4_d  = accept ? fetch_pcp4 : pcp4_q;
    end
  end
  // Fetch control; a redirect arriving mid-request is parked until the response retires
  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    if (state_q == IDLE) begin
      pcf_d   = redir ? target : pcf_q;
      state_d = (!redir && !StallF && !buf_valid_q) ? REQ : IDLE;
    end else if (IMemReady) begin
      pcf_d        = accept ? fetch_pcp4 : (redir ? target : redir_pc_q);
      redir_pend_d = 1'b0;
      state_d      = (accept && !StallF && !buf_valid_d) ? REQ : IDLE;
    end else if (redir) begin
      redir_pc_d   = target;
      redir_pend_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pcf_q        <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
      instr_q      <= '0;
      pcp4_q       <= '0;
      valid_q      <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_instr_q  <= '0;
      buf_pcp4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      instr_q      <= instr_d;
      pcp4_q       <= pcp4_d;
      valid_q      <= valid_d;
      buf_valid_q  <= buf_valid_d;
      buf_instr_q  <= buf_instr_d;
      buf_pcp4_q   <= buf_pcp4_d;
    end
  end
`ifdef PC_ALIGN_CHECK_EN
  logic adelf_q, adelf_d;
  assign adelf_d = adelf_q | (redir & |PCBranchD[1:0]);
  assign AdELF   = adelf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) adelf_q <= 1'b0;
    else adelf_q <= adelf_d;
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch_stage bench against a queue-based behavioural model, plus directed literal checks.
module tb_fetch_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic StallF = 0, StallD = 0, FlushD = 0, PCSrcD = 0, IMemReady = 0;
  logic [31:0] PCBranchD = '0, IMemRData = '0;
  logic IMemReq, ValidD;
  logic [31:0] IMemAddr, InstrD, PCPlus4D, PCF;
`ifdef PC_ALIGN_CHECK_EN
  logic AdELF;
`endif
  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemReady(IMemReady), .IMemRData(IMemRData), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .PCF(PCF)
`ifdef PC_ALIGN_CHECK_EN
    , .AdELF(AdELF)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic [31:0] instr; logic [31:0] pcp4; } ent_t;
  ent_t q[$];
  bit m_busy, m_pend, m_valid, m_adel;
  logic [31:0] m_pc, m_rpc, m_instr, m_p4;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic void model_reset();
    q.delete();
    m_busy = 0; m_pend = 0; m_valid = 0; m_adel = 0;
    m_pc = 32'hBFC0_0000; m_rpc = '0; m_instr = '0; m_p4 = '0;
  endfunction
  function automatic void check_model();
    chk("req", IMemReq, m_busy);
    chk("addr", IMemAddr, m_pc);
    chk("pcf", PCF, m_pc);
    chk("valid", ValidD, m_valid);
    chk("instr", InstrD, m_instr);
    chk("pcp4", PCPlus4D, m_p4);
`ifdef PC_ALIGN_CHECK_EN
    chk("adelf", AdELF, m_adel);
`endif
  endfunction
  // One clock of the spec's rules: a response retires, the IF/ID path is a FIFO fed by responses, PC follows.
  function automatic void model_next();
    bit redir, fire, take;
    int depth0;
    logic [31:0] tgt, pc0;
    ent_t e;
    redir  = PCSrcD && !StallD;
    tgt    = {PCBranchD[31:2], 2'b00};
    fire   = m_busy && IMemReady;
    take   = fire && !m_pend && !redir;
    pc0    = m_pc;
    depth0 = q.size();
    e.instr = IMemRData;
    e.pcp4  = pc0 + 32'd4;
    if (redir && PCBranchD[1:0] != 2'b00) m_adel = 1;
    if (StallD) begin
      if (take) q.push_back(e);
    end else if (FlushD || redir) begin
      m_valid = 0;
      q.delete();
    end else begin
      if (take) q.push_back(e);
      if (q.size() > 0) begin
        e = q.pop_front();
        m_instr = e.instr; m_p4 = e.pcp4; m_valid = 1;
      end else m_valid = 0;
    end
    if (!m_busy) begin
      if (redir) m_pc = tgt;
      else if (!StallF && depth0 == 0) m_busy = 1;
    end else if (fire) begin
      m_pc   = take ? pc0 + 32'd4 : (redir ? tgt : m_rpc);
      m_pend = 0;
      m_busy = take && !StallF && q.size() == 0;
    end else if (redir) begin
      m_rpc = tgt; m_pend = 1;
    end
  endfunction
  task automatic step(input bit sf, input bit sd, input bit fl, input bit ps,
                      input logic [31:0] pb, input bit rdy, input logic [31:0] rd);
    check_model();
    StallF = sf; StallD = sd; FlushD = fl; PCSrcD = ps; PCBranchD = pb;
    IMemReady = rdy; IMemRData = rd;
    if (rst_n) model_next();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pcf", PCF, 32'hBFC0_0000);
    chk("rst_req", IMemReq, 0);
    chk("rst_valid", ValidD, 0);
    chk("rst_instr", InstrD, 0);
    rst_n = 1'b1;
    // streaming from reset
    step(0, 0, 0, 0, 0, 1, 32'h1111_0000);
    chk("s_req", IMemReq, 1);
    chk("s_addr0", IMemAddr, 32'hBFC0_0000);
    step(0, 0, 0, 0, 0, 1, 32'hA0A0_A0A0);
    chk("s_valid", ValidD, 1);
    chk("s_p4", PCPlus4D, 32'hBFC0_0004);
    chk("s_instr", InstrD, 32'hA0A0_A0A0);
    chk("s_addr1", IMemAddr, 32'hBFC0_0004);
    step(0, 0, 0, 0, 0, 1, 32'hB0B0_B0B0);
    chk("s_addr2", IMemAddr, 32'hBFC0_0008);
    // redirect while response is late
    step(0, 0, 0, 1, 32'h0040_0020, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("r_valid", ValidD, 0);
    chk("r_pcf", PCF, 32'h0040_0020);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("r_req", IMemReq, 1);
    chk("r_addr", IMemAddr, 32'h0040_0020);
    // redirect coinciding with ready
    step(0, 0, 0, 1, 32'h0000_0100, 1, 32'hBAD0_0001);
    chk("c_valid", ValidD, 0);
    chk("c_pcf", PCF, 32'h0000_0100);
    // PC wrap
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    chk("w_pcf", PCF, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hC0C0_C0C0);
    chk("w_pcf0", PCF, 0);
    chk("w_p4", PCPlus4D, 0);
    chk("w_valid", ValidD, 1);
    // StallF during an outstanding request
    step(1, 0, 0, 0, 0, 0, 0);
    chk("f_req_held", IMemReq, 1);
    step(1, 0, 0, 0, 0, 1, 32'hE0E0_E0E0);
    chk("f_req_drop", IMemReq, 0);
    chk("f_instr", InstrD, 32'hE0E0_E0E0);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("f_no_req", IMemReq, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("f_req_again", IMemReq, 1);
    // StallD with a response in flight
    step(0, 0, 0, 0, 0, 1, 32'hF0F0_F0F0);
    step(0, 1, 0, 0, 0, 1, 32'h6060_6060);
    chk("d_hold", InstrD, 32'hF0F0_F0F0);
    chk("d_req0", IMemReq, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    chk("d_req1", IMemReq, 0);
    chk("d_hold2", InstrD, 32'hF0F0_F0F0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("d_buf", InstrD, 32'h6060_6060);
    chk("d_buf_p4", PCPlus4D, 32'h0000_000C);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("d_resume", IMemAddr, 32'h0000_000C);
`ifdef PC_ALIGN_CHECK_EN
    step(0, 0, 0, 1, 32'h0000_0102, 0, 0);
    chk("a_adelf", AdELF, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("a_pcf", PCF, 32'h0000_0100);
`endif
    // randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        step(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
      end else begin
        step($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 1) == 1, $urandom);
      end
    end
    check_model();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline, directly upstream of the decode-stage branch resolver.
- Owns PCF and drives a single-outstanding request/ready handshake to instruction memory.
- Holds the IF/ID pipeline register plus a one-entry skid buffer.
- Consumes PCSrcD/PCBranchD from decode to redirect fetch; no branch delay slot, so wrong-path fetches are squashed.

Parameters:
WIDTH, 32, datapath and address width
RESET_PC, 32'hBFC0_0000, PCF value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
StallF  in  1  hazard unit: do not launch a new fetch
StallD  in  1  hazard unit: hold IF/ID register
FlushD  in  1  hazard unit: bubble IF/ID on the next edge
PCSrcD  in  1  branch/jump taken, resolved in decode
PCBranchD  in  WIDTH  redirect target
IMemReq  out  1  fetch request
IMemAddr  out  WIDTH  fetch address, equals PCF
IMemReady  in  1  response valid this cycle; data on IMemRData
IMemRData  in  WIDTH  fetched instruction
InstrD  out  WIDTH  IF/ID instruction
PCPlus4D  out  WIDTH  IF/ID fetched PC + 4
ValidD  out  1  IF/ID holds a real instruction
PCF  out  WIDTH  current fetch PC

Behaviour:
- Reset, asynchronous and active-low:
  - PCF=RESET_PC; InstrD=0; PCPlus4D=0; ValidD=0; IMemReq=0.
  - Buffer empty; RedirPend=0; state IDLE.
- Redirect event (Redir) = PCSrcD & !StallD. It is ignored while StallD=1.
- State machine has two states, IDLE and REQ:
  - IDLE:
    - IMemReq=0.
    - If Redir: PCF<=PCBranchD and stay in IDLE.
    - Else if !StallF & buffer empty: go to REQ.
  - REQ:
    - IMemReq=1 and IMemAddr=PCF, both held stable until IMemReady. A request is never withdrawn, including when StallF rises.
    - On IMemReady with no redirect (RedirPend=0 & !Redir): the response is accepted and PCF<=PCF+4.
      - Next state is REQ if !StallF and the buffer will be empty next cycle; otherwise IDLE.
    - On IMemReady with RedirPend=1 or Redir: the data is discarded. PCF<=PCBranchD if Redir, else RedirPC. RedirPend<=0; next state IDLE.
    - Redir without IMemReady: RedirPC<=PCBranchD; RedirPend<=1. A later Redir overwrites RedirPC.
- Response latency: zero or more cycles after the request. Combinational ready in the same cycle as the request is legal.
- IF/ID update, in priority order:
  - StallD=1: hold InstrD, PCPlus4D and ValidD. An accepted response goes into the buffer.
  - FlushD | Redir: ValidD<=0. The buffer is cleared and any same-cycle response is dropped.
  - Buffer valid: load from the buffer and empty it. A same-cycle accepted response refills the buffer.
  - Accepted response: InstrD<=IMemRData; PCPlus4D<=fetched PC+4; ValidD<=1.
  - Otherwise: ValidD<=0 (bubble).
- A full buffer blocks new requests, so the pipeline never drops a non-squashed instruction.
- PC arithmetic is modulo 2^WIDTH; 32'hFFFF_FFFC+4 wraps to 0.
- Reset asserted mid-request: the request is abandoned. The memory side must tolerate IMemReq dropping on reset.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output AdELF (1 bit, reset 0).
  - A redirect target with bits [1:0]!=0 sets AdELF sticky until reset.
  - PCF still loads the target with bits [1:0] forced to 0.
- Undefined: the AdELF port is absent; target bits [1:0] are silently cleared.

Test Plan:
- Reset release, IMemReady tied 1, no stalls -> IMemAddr sequence BFC00000, BFC00004, BFC00008 on consecutive cycles; ValidD=1 from the second edge with PCPlus4D=BFC00004.
- Redirect with IMemReady low 3 cycles: PCSrcD=1, PCBranchD=00400020 one cycle mid-request -> returned data discarded; ValidD=0; next IMemAddr=00400020.
- StallD high 2 cycles during streaming -> InstrD held; the in-flight response is buffered; IMemReq stays 0 while the buffer is full; after release, instructions appear in order with no loss or duplicate.
- Same-cycle PCSrcD=1 and IMemReady=1 with PCBranchD=00000100 -> data dropped; ValidD=0 next cycle; PCF=00000100.
- StallF asserted while in REQ -> IMemReq stays 1 until ready; no new request is issued afterwards until StallF falls.
- PCF=FFFFFFFC, response accepted -> PCF=00000000 and PCPlus4D=00000000. With PC_ALIGN_CHECK_EN, redirect to 00000102 -> AdELF=1 and PCF=00000100.
